display_arbiter: RTL and testbench
==================================

# display_arbiter

Shares the four-digit seven-segment display between three requesters: the game/status FSM, the score path and the debug readout. It grants display ownership round-robin with a guaranteed minimum tenure, so no source flickers off before a human can read it. It registers the 16-bit hex word of the current owner onto `digit3..digit0`, which feed the `display` multiplexer directly. When no source is requesting, it shows a fixed idle pattern.

## Interface
- `HOLD_CYCLES`, default 50_000_000. Minimum tenure in clock cycles, 0.5 s at 100 MHz. Legal range is 1 to 2^32-1.
- `IDLE_VALUE`, default 16'h0000. Word shown while no requester owns the display.

Ports:
- `clk_100MHz` in, 1: system clock. One clock domain; all logic is on its rising edge.
- `reset` in, 1: reset, synchronous and active-high.
- `req0`, `req1`, `req2` in, 1 each: request for display ownership. Level-sensitive.
- `val0`, `val1`, `val2` in, 16 each: hex word of each requester. Bits [15:12] map to the leftmost digit.
- `grant` out, 3: one-hot owner. 3'b000 means idle.
- `busy` out, 1: high while in state HOLD.
- `digit3`, `digit2`, `digit1`, `digit0` out, 4 each: registered nibbles of the displayed word.

## Operation
- States:
  - IDLE: `grant`=000, digits = `IDLE_VALUE`.
  - HOLD: one requester owns the display.
- Registers:
  - `cnt`: tenure down-counter, width $clog2(HOLD_CYCLES+1).
  - `last`: 2-bit index of the most recent owner.
- Round-robin pick:
  - Search order is `last`+1, `last`+2, `last` (mod 3).
  - The first index whose req is high wins.
  - `last` updates to the winner on every grant.
- IDLE to HOLD: any req high.
  - Grant the pick.
  - Load `cnt` = HOLD_CYCLES-1.
  - Latch the winner's val into the digits.
- HOLD with `cnt` > 0:
  - `cnt` decrements each cycle.
  - The owner cannot be pre-empted.
- HOLD with `cnt` = 0, the decision cycle. Evaluate every cycle until one of these applies:
  - A non-owner req is high: grant the round-robin pick among the other requesters. The current owner is excluded from the pick even if its req is still high. Reload `cnt`. The grant switches with no idle gap.
  - Otherwise, owner req high: stay in HOLD, `cnt` stays 0, digits keep tracking the owner.
  - Otherwise: go to IDLE.
- Digit source during HOLD:
  - While the owner's req is high, digits load the owner's val every cycle (live update).
  - When the owner drops req early, digits freeze at the last loaded value. The grant is kept until `cnt` reaches 0.
- Non-owner val and req changes have no effect on the outputs except through arbitration.
- `busy` = (state == HOLD).
- Reset:
  - state IDLE, `grant`=000, `busy`=0, `cnt`=0.
  - `last`=2, so requester 0 wins first.
  - digits = `IDLE_VALUE` nibbles.
  - Reset has priority over every transition, including mid-tenure and the decision cycle.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Request latency: req sampled high at edge t gives `grant`, `busy` and digits updated at t+1. The digits show val as sampled at t.
- Live value update inside a tenure: val change at t appears on the digits at t+1.
- Tenure: the first grant cycle is g, with `cnt` = HOLD_CYCLES-1.
  - The decision cycle is g+HOLD_CYCLES-1.
  - The earliest new owner is visible at g+HOLD_CYCLES.
  - Minimum ownership is therefore exactly HOLD_CYCLES cycles.
- Extended tenure (`cnt` = 0): a competing req rising at edge t moves the grant at t+1.
- Owner release at the decision cycle with no other req: IDLE at the next cycle, with `grant`=000 and digits = `IDLE_VALUE`.
- HOLD_CYCLES = 1: every HOLD cycle is a decision cycle. Simultaneous persistent requesters rotate every cycle.
- Reset asserted at edge t: reset values are visible at t+1. The first grant is possible at the first edge after reset deasserts.

## Test plan
Use HOLD_CYCLES=4 and IDLE_VALUE=16'h0000 unless stated.
- Reset then idle: with all reqs low, digits stay 0,0,0,0, `grant`=000, `busy`=0 for 10 cycles.
- Single requester with live update:
  - req0=1, val0=16'h1234 at t: `grant`=001 and digits 1,2,3,4 at t+1.
  - val0 changes to 16'h5678 at t+2: digits 5,6,7,8 at t+3.
  - req0 held for 20 cycles: `grant` stays 001 throughout.
- Round-robin:
  - req0, req1 and req2 all held high: `grant` sequence 001, 010, 100, 001, each held exactly 4 cycles.
  - Digits show val0, val1, val2 in turn.
- Early release:
  - req1 alone (val1=16'hABCD) is granted at g, then drops req at g+1: digits stay A,B,C,D and `grant`=010 through g+3.
  - At g+4: `grant`=000 and digits 0,0,0,0.
- Extended tenure pre-empted: req0 owns the display for 10 cycles (`cnt`=0), then req2 rises at t: `grant`=100 at t+1.
- Reset mid-tenure:
  - `reset` at g+1 during a req2 tenure: `grant`=000 and digits 0 at g+2.
  - After reset deasserts with req1 and req2 both high: `grant`=010 first.

Source files
------------

// File: rtl/display_arbiter.sv
// display_arbiter: round-robin owner of the four-digit display with a minimum tenure.
// The owner's 16-bit word is registered onto digit3..digit0. IDLE_VALUE is shown when
// nobody owns the display.
module display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter logic [15:0] IDLE_VALUE  = 16'h0000
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        req2,
  input  logic [15:0] val0,
  input  logic [15:0] val1,
  input  logic [15:0] val2,
  output logic [2:0]  grant,
  output logic        busy,
  output logic [3:0]  digit3,
  output logic [3:0]  digit2,
  output logic [3:0]  digit1,
  output logic [3:0]  digit0
);

  // 64-bit sum so HOLD_CYCLES = 2^32-1 does not wrap before $clog2.
  localparam int unsigned CntW = $clog2(64'(HOLD_CYCLES) + 64'd1);
  localparam logic [CntW-1:0] CntReload = CntW'(HOLD_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e          state_q, state_d;
  logic [1:0]      last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      grant_q, grant_d;
  logic [15:0]     word_q, word_d;

  logic [2:0]  reqs;
  logic [15:0] vals [3];

  assign reqs    = {req2, req1, req0};
  assign vals[0] = val0;
  assign vals[1] = val1;
  assign vals[2] = val2;

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  // Round-robin candidates after the most recent owner: last+1 then last+2 (mod 3).
  logic [1:0] nxt1, nxt2, other_idx, full_idx;
  logic       other_hit, any_hit;

  // Candidate ordering and pick: "other" excludes last (the owner while in HOLD).
  always_comb begin
    nxt1 = 2'd0;
    nxt2 = 2'd1;
    unique case (last_q)
      2'd0: begin
        nxt1 = 2'd1;
        nxt2 = 2'd2;
      end
      2'd1: begin
        nxt1 = 2'd2;
        nxt2 = 2'd0;
      end
      default: begin
        nxt1 = 2'd0;
        nxt2 = 2'd1;
      end
    endcase
    other_hit = reqs[nxt1] | reqs[nxt2];
    other_idx = reqs[nxt1] ? nxt1 : nxt2;
    any_hit   = other_hit | reqs[last_q];
    full_idx  = other_hit ? other_idx : last_q;
  end

  // Next-state: grant on request, hold for the tenure, decide when the counter hits zero.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    word_d  = word_q;
    unique case (state_q)
      StIdle: begin
        if (any_hit) begin
          state_d = StHold;
          last_d  = full_idx;
          cnt_d   = CntReload;
          grant_d = onehot(full_idx);
          word_d  = vals[full_idx];
        end
      end
      StHold: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
          // Owner dropping req early freezes the digits but keeps the grant.
          if (reqs[last_q]) word_d = vals[last_q];
        end else if (other_hit) begin
          last_d  = other_idx;
          cnt_d   = CntReload;
          grant_d = onehot(other_idx);
          word_d  = vals[other_idx];
        end else if (reqs[last_q]) begin
          word_d = vals[last_q];
        end else begin
          state_d = StIdle;
          grant_d = 3'b000;
          word_d  = IDLE_VALUE;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = 3'b000;
        word_d  = IDLE_VALUE;
      end
    endcase
  end

  // State register with synchronous reset; last=2 makes requester 0 win first.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q <= StIdle;
      last_q  <= 2'd2;
      cnt_q   <= '0;
      grant_q <= 3'b000;
      word_q  <= IDLE_VALUE;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      word_q  <= word_d;
    end
  end

  assign grant  = grant_q;
  assign busy   = (state_q == StHold);
  assign digit3 = word_q[15:12];
  assign digit2 = word_q[11:8];
  assign digit1 = word_q[7:4];
  assign digit0 = word_q[3:0];

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter: directed scenarios then random traffic, all checked against
// an owner/tenure-age reference model.
module tb_display_arbiter;

  localparam int unsigned Hold = 4;
  localparam logic [15:0] Idle = 16'h0000;

  logic        clk_100MHz = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, req2 = 1'b0;
  logic [15:0] val0 = '0, val1 = '0, val2 = '0;
  logic [2:0]  grant;
  logic        busy;
  logic [3:0]  digit3, digit2, digit1, digit0;

  always #5 clk_100MHz = ~clk_100MHz;

  display_arbiter #(
    .HOLD_CYCLES(Hold),
    .IDLE_VALUE (Idle)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .req2      (req2),
    .val0      (val0),
    .val1      (val1),
    .val2      (val2),
    .grant     (grant),
    .busy      (busy),
    .digit3    (digit3),
    .digit2    (digit2),
    .digit1    (digit1),
    .digit0    (digit0)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference: who owns the display, how many cycles it has owned it, what is shown.
  int          m_owner = -1;
  int          m_last  = 2;
  int          m_age   = 0;
  logic [15:0] m_shown = Idle;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [2:0]  r;
    logic [15:0] v [3];
    int          w;
    r    = {req2, req1, req0};
    v[0] = val0;
    v[1] = val1;
    v[2] = val2;
    w    = -1;
    if (reset) begin
      m_owner = -1;
      m_last  = 2;
      m_age   = 0;
      m_shown = Idle;
    end else if (m_owner < 0) begin
      for (int k = 3; k >= 1; k--) if (r[(m_last + k) % 3]) w = (m_last + k) % 3;
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_age   = 1;
        m_shown = v[w];
      end
    end else if (m_age < int'(Hold)) begin
      m_age++;
      if (r[m_owner]) m_shown = v[m_owner];
    end else begin
      // Tenure served: the owner itself is not a candidate for the handover.
      for (int k = 2; k >= 1; k--) if (r[(m_owner + k) % 3]) w = (m_owner + k) % 3;
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_age   = 1;
        m_shown = v[w];
      end else if (r[m_owner]) begin
        m_shown = v[m_owner];
      end else begin
        m_owner = -1;
        m_age   = 0;
        m_shown = Idle;
      end
    end
  endtask

  function automatic logic [15:0] digits();
    return {digit3, digit2, digit1, digit0};
  endfunction

  // One clock: model follows the sampled inputs, outputs are compared 1 time unit later.
  task automatic tick();
    @(posedge clk_100MHz);
    model_step();
    #1;
    check("grant", {13'b0, grant}, (m_owner < 0) ? 16'h0 : 16'(1 << m_owner));
    check("busy", {15'b0, busy}, {15'b0, m_owner >= 0});
    check("digits", digits(), m_shown);
  endtask

  task automatic do_reset();
    {req2, req1, req0} = 3'b000;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #1;
    // Reset then idle.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_grant", {13'b0, grant}, 16'h0000);
      check("idle_digits", digits(), 16'h0000);
    end

    // Single requester, live value update, no pre-emption for 20 cycles.
    val0 = 16'h1234;
    req0 = 1'b1;
    tick();
    check("single_grant", {13'b0, grant}, 16'h0001);
    check("single_digits", digits(), 16'h1234);
    tick();
    val0 = 16'h5678;
    tick();
    check("live_digits", digits(), 16'h5678);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("single_hold", {13'b0, grant}, 16'h0001);
    end

    // Round-robin with all three requesting: 4 cycles each.
    do_reset();
    val0 = 16'h1111;
    val1 = 16'h2222;
    val2 = 16'h3333;
    {req2, req1, req0} = 3'b111;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("rr_grant", {13'b0, grant}, 16'(1 << ((i / 4) % 3)));
      check("rr_digits", digits(), 16'h1111 * 16'(((i / 4) % 3) + 1));
    end

    // Early release: grant kept until the tenure ends, digits frozen.
    do_reset();
    val1 = 16'hABCD;
    req1 = 1'b1;
    tick();
    check("early_g", {13'b0, grant}, 16'h0002);
    req1 = 1'b0;
    val1 = 16'h0F0F;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("early_hold_grant", {13'b0, grant}, 16'h0002);
      check("early_hold_digits", digits(), 16'hABCD);
    end
    tick();
    check("early_idle_grant", {13'b0, grant}, 16'h0000);
    check("early_idle_digits", digits(), 16'h0000);

    // Extended tenure pre-empted immediately by a competitor.
    do_reset();
    val0 = 16'h0A0A;
    val2 = 16'hC0DE;
    req0 = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    req2 = 1'b1;
    tick();
    check("preempt_grant", {13'b0, grant}, 16'h0004);
    check("preempt_digits", digits(), 16'hC0DE);

    // Reset mid-tenure, then requester 1 wins over 2.
    do_reset();
    req2 = 1'b1;
    tick();
    check("mid_g", {13'b0, grant}, 16'h0004);
    reset = 1'b1;
    tick();
    check("mid_rst_grant", {13'b0, grant}, 16'h0000);
    check("mid_rst_digits", digits(), 16'h0000);
    reset = 1'b0;
    req1 = 1'b1;
    tick();
    check("post_rst_grant", {13'b0, grant}, 16'h0002);

    // Random traffic with sticky requests and occasional reset.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) {req2, req1, req0} = 3'($urandom_range(7));
      if ($urandom_range(1) == 0) val0 = 16'($urandom);
      if ($urandom_range(1) == 0) val1 = 16'($urandom);
      if ($urandom_range(1) == 0) val2 = 16'($urandom);
      reset = ($urandom_range(59) == 0);
      tick();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
